// File: rtl/piece_queue.sv
// Piece preview FIFO: turns random words into (shape, rotation) pieces, rejects
// illegal shapes and immediate repeats, and serves one piece per spawn request.
module piece_queue #(
    parameter int DEPTH  = 4,
    parameter int SHAPES = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [15:0]              rand_in,
    input  logic                     rand_valid,
    input  logic                     piece_req,
    output logic                     piece_valid,
    output logic [2:0]               piece_shape,
    output logic [1:0]               piece_rot,
    output logic                     next_valid,
    output logic [2:0]               next_shape,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;
    localparam logic [2:0] NO_SHAPE = 3'd7;

    function automatic logic shape_legal(input logic [2:0] s);
        return (int'(s) < SHAPES);
    endfunction

    // Entries are stored as {shape, rot}.
    logic [4:0]    mem_r [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic [2:0]    last_shape_r;
    logic          reroll_r;
    logic [0:0]    state_r;

    logic [0:0]    state_next_s;
    logic          pop_s;
    logic          room_s;
    logic          offer_s;
    logic          repeat_s;
    logic          push_s;
    logic [CW-1:0] count_next_s;
    logic [PW-1:0] rd_next_s;
    logic [PW-1:0] nx_idx_s;
    logic [4:0]    cand_ent_s;
    logic [4:0]    head_ent_s;
    logic [4:0]    nx_ent_s;

    assign count = count_r;

    // Push/pop decision and look-ahead of the head and second entry after this edge.
    always_comb begin
        cand_ent_s   = {rand_in[2:0], rand_in[9:8]};
        pop_s        = piece_req && (count_r != {CW{1'b0}});
        room_s       = (count_r < CW'(DEPTH)) || pop_s;
        offer_s      = en && rand_valid && room_s && shape_legal(rand_in[2:0]);
        repeat_s     = !reroll_r && (rand_in[2:0] == last_shape_r);
        push_s       = offer_s && !repeat_s;
        count_next_s = count_r + CW'(push_s) - CW'(pop_s);
        rd_next_s    = rd_ptr_r + PW'(pop_s);
        nx_idx_s     = rd_next_s + PW'(1'b1);
        // A word written this edge may already be the head or second entry.
        if (push_s && (wr_ptr_r == rd_next_s)) begin
            head_ent_s = cand_ent_s;
        end else begin
            head_ent_s = mem_r[rd_next_s];
        end
        if (push_s && (wr_ptr_r == nx_idx_s)) begin
            nx_ent_s = cand_ent_s;
        end else begin
            nx_ent_s = mem_r[nx_idx_s];
        end
        state_next_s = state_r;
        case (state_r)
            ST_FILL: begin
                if (count_next_s == CW'(DEPTH)) begin
                    state_next_s = ST_READY;
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            ST_READY: begin
                if (pop_s) begin
                    state_next_s = ST_FILL;
                end else begin
                    state_next_s = ST_READY;
                end
            end
            default: state_next_s = ST_FILL;
        endcase
    end

    // Queue storage, pointers, anti-repeat state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 5'd0;
            end
            rd_ptr_r     <= {PW{1'b0}};
            wr_ptr_r     <= {PW{1'b0}};
            count_r      <= {CW{1'b0}};
            last_shape_r <= NO_SHAPE;
            reroll_r     <= 1'b0;
            state_r      <= ST_FILL;
            underflow    <= 1'b0;
            piece_valid  <= 1'b0;
            piece_shape  <= 3'd0;
            piece_rot    <= 2'd0;
            next_valid   <= 1'b0;
            next_shape   <= 3'd0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= cand_ent_s;
                wr_ptr_r        <= wr_ptr_r + PW'(1'b1);
                last_shape_r    <= rand_in[2:0];
                reroll_r        <= 1'b0;
            end else if (offer_s && repeat_s) begin
                reroll_r <= 1'b1;
            end
            if (piece_req && (count_r == {CW{1'b0}})) begin
                underflow <= 1'b1;
            end
            rd_ptr_r    <= rd_next_s;
            count_r     <= count_next_s;
            state_r     <= state_next_s;
            piece_valid <= (count_next_s != {CW{1'b0}});
            next_valid  <= (count_next_s > CW'(1));
            piece_shape <= (count_next_s != {CW{1'b0}}) ? head_ent_s[4:2] : 3'd0;
            piece_rot   <= (count_next_s != {CW{1'b0}}) ? head_ent_s[1:0] : 2'd0;
            next_shape  <= (count_next_s > CW'(1)) ? nx_ent_s[4:2] : 3'd0;
        end
    end
endmodule

// File: tb/tb_piece_queue.sv
// Scoreboard bench for piece_queue: a reference queue model predicts every
// push/pop and the head/next/count/underflow outputs are compared each cycle.
module tb_piece_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [15:0] rand_in = 16'h0000;
    logic        rand_valid = 1'b0;
    logic        piece_req = 1'b0;
    logic        piece_valid;
    logic [2:0]  piece_shape;
    logic [1:0]  piece_rot;
    logic        next_valid;
    logic [2:0]  next_shape;
    logic [2:0]  count;
    logic        underflow;

    int n_checks = 0;
    int n_pass = 0;

    logic [4:0] sb_q[$];
    logic [2:0] m_last;
    logic       m_reroll;
    logic       m_uf;

    piece_queue #(.DEPTH(4), .SHAPES(7)) dut (
        .clk(clk), .rst(rst), .en(en), .rand_in(rand_in), .rand_valid(rand_valid),
        .piece_req(piece_req), .piece_valid(piece_valid), .piece_shape(piece_shape),
        .piece_rot(piece_rot), .next_valid(next_valid), .next_shape(next_shape),
        .count(count), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_last   = 3'd7;
        m_reroll = 1'b0;
        m_uf     = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_pv"}, 32'(piece_valid), 32'd0);
        check({tag, "_shape"}, 32'(piece_shape), 32'd0);
        check({tag, "_rot"}, 32'(piece_rot), 32'd0);
        check({tag, "_nv"}, 32'(next_valid), 32'd0);
        check({tag, "_nshape"}, 32'(next_shape), 32'd0);
        check({tag, "_uf"}, 32'(underflow), 32'd0);
    endtask

    task automatic check_all();
        logic [4:0] h;
        logic [4:0] nx;
        check("count", 32'(count), 32'(sb_q.size()));
        check("piece_valid", 32'(piece_valid), 32'(sb_q.size() >= 1));
        check("next_valid", 32'(next_valid), 32'(sb_q.size() >= 2));
        check("underflow", 32'(underflow), 32'(m_uf));
        if (sb_q.size() >= 1) begin
            h = sb_q[0];
            check("head_shape", 32'(piece_shape), 32'(h[4:2]));
            check("head_rot", 32'(piece_rot), 32'(h[1:0]));
        end
        if (sb_q.size() >= 2) begin
            nx = sb_q[1];
            check("next_shape", 32'(next_shape), 32'(nx[4:2]));
        end
    endtask

    // Called at a falling edge: drive inputs, advance the model, sample at the next falling edge.
    task automatic step(input logic [15:0] r, input logic v, input logic e, input logic req);
        logic [2:0] c;
        logic pop, room, offer, rep, push;
        int n;
        rand_in = r; rand_valid = v; en = e; piece_req = req;
        n = sb_q.size();
        c = r[2:0];
        pop   = req && (n > 0);
        room  = (n < 4) || pop;
        offer = e && v && room && (c < 3'd7);
        rep   = !m_reroll && (c == m_last);
        push  = offer && !rep;
        if (req && n == 0) m_uf = 1'b1;
        if (push) begin
            m_reroll = 1'b0;
            m_last = c;
        end else if (offer) begin
            m_reroll = 1'b1;
        end
        if (pop) void'(sb_q.pop_front());
        if (push) sb_q.push_back({c, r[9:8]});
        @(posedge clk);
        @(negedge clk);
        rand_valid = 1'b0;
        piece_req = 1'b0;
        check_all();
    endtask

    // Asserts reset between clock edges and checks outputs clear without a clock edge.
    task automatic do_reset(input string tag);
        #2 rst = 1'b0;
        #1 check_zero(tag);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;

        // fill from empty
        step(16'h0001, 1'b1, 1'b1, 1'b0);
        check("first_pv", 32'(piece_valid), 32'd1);
        step(16'h0102, 1'b1, 1'b1, 1'b0);
        step(16'h0203, 1'b1, 1'b1, 1'b0);
        step(16'h0304, 1'b1, 1'b1, 1'b0);
        check("fill_count", 32'(count), 32'd4);
        check("fill_head", 32'(piece_shape), 32'd1);
        check("fill_next", 32'(next_shape), 32'd2);
        check("fill_state", 32'(dut.state_r), 32'd1);
        step(16'h0005, 1'b1, 1'b1, 1'b0);
        check("full_hold", 32'(count), 32'd4);
        repeat (4) step(16'h0000, 1'b0, 1'b0, 1'b1);

        // illegal shapes rejected
        repeat (5) step(16'h0007, 1'b1, 1'b1, 1'b0);
        step(16'h0005, 1'b1, 1'b1, 1'b0);
        check("reject_count", 32'(count), 32'd1);
        step(16'h0000, 1'b0, 1'b0, 1'b1);

        // anti-repeat
        step(16'h0003, 1'b1, 1'b1, 1'b0);
        step(16'h0003, 1'b1, 1'b1, 1'b0);
        check("reroll_reject", 32'(count), 32'd1);
        step(16'h0003, 1'b1, 1'b1, 1'b0);
        check("reroll_accept", 32'(count), 32'd2);
        check("reroll_next", 32'(next_shape), 32'd3);
        repeat (2) step(16'h0000, 1'b0, 1'b0, 1'b1);

        // simultaneous push and pop while full
        step(16'h0001, 1'b1, 1'b1, 1'b0);
        step(16'h0002, 1'b1, 1'b1, 1'b0);
        step(16'h0003, 1'b1, 1'b1, 1'b0);
        step(16'h0004, 1'b1, 1'b1, 1'b0);
        step(16'h0006, 1'b1, 1'b1, 1'b1);
        check("coll_head", 32'(piece_shape), 32'd2);
        check("coll_count", 32'(count), 32'd4);
        repeat (4) step(16'h0000, 1'b0, 1'b0, 1'b1);

        // underflow is sticky; push with pop on empty
        do_reset("rst_uf");
        step(16'h0000, 1'b0, 1'b0, 1'b1);
        check("uf_set", 32'(underflow), 32'd1);
        check("uf_count", 32'(count), 32'd0);
        step(16'h0001, 1'b1, 1'b1, 1'b1);
        check("uf_push_empty", 32'(count), 32'd1);
        step(16'h0202, 1'b1, 1'b1, 1'b0);
        check("uf_sticky", 32'(underflow), 32'd1);

        // async reset mid-operation clears last_shape
        do_reset("rst_mid_a");
        step(16'h0001, 1'b1, 1'b1, 1'b0);
        step(16'h0002, 1'b1, 1'b1, 1'b0);
        step(16'h0003, 1'b1, 1'b1, 1'b0);
        check("mid_count", 32'(count), 32'd3);
        do_reset("rst_mid");
        step(16'h0003, 1'b1, 1'b1, 1'b0);
        check("post_rst_push", 32'(count), 32'd1);

        // random traffic against the model
        do_reset("rst_rand");
        for (int i = 0; i < 400; i++) begin
            step(16'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 2) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/piece_queue.md
# piece_queue

Consumer side of the random-number path: samples the 16-bit random word, converts it to a block shape (0–6) and rotation (0–3), and keeps a small preview FIFO of upcoming pieces. The game-control FSM pops one piece per spawn. The first preview entry is exposed for the "next piece" display. The block sits between the random generator output and the board/spawn logic.

## Interface
Parameters:
- DEPTH, 4: FIFO entries (current + previews); power of two, 2..8.
- SHAPES, 7: legal shape codes 0..SHAPES-1; must be ≤ 7.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-low.
- en  input  1  fill enable; when 0 no new pieces are generated (pop still allowed).
- rand_in  input  16  random word from the generator.
- rand_valid  input  1  rand_in is fresh this cycle.
- piece_req  input  1  one-cycle pop request from the spawn FSM.
- piece_valid  output  1  head entry present (count ≥ 1).
- piece_shape  output  3  head shape.
- piece_rot  output  2  head rotation.
- next_valid  output  1  count ≥ 2.
- next_shape  output  3  shape of entry after head.
- count  output  $clog2(DEPTH)+1  occupancy.
- underflow  output  1  sticky: piece_req seen while empty.

## Operation
- Candidate per cycle: cand = rand_in[2:0], rot = rand_in[9:8].
- Accept/push when all hold: en=1, rand_valid=1, count<DEPTH (or a pop in the same cycle), and cand<SHAPES.
- Anti-repeat: if cand equals last_shape and reroll=0, reject it and set reroll=1. While reroll=1, accept any cand<SHAPES and clear reroll on the push.
- last_shape is updated on every push. Its reset value is 7, meaning "none".
- FSM, two states:
  - FILL (reset state): pushes as above; goes to READY when count reaches DEPTH.
  - READY: no pushes until a pop; on a pop goes to FILL.
- The FSM is informational only. The push condition above is authoritative.
- Pop: piece_req=1 and count>0 advances the head pointer. A pop when count=0 is ignored, count stays 0, and underflow is set.
- Simultaneous push and pop with count=DEPTH or 0<count<DEPTH: both happen and count is unchanged. The pushed entry lands at the tail.
- Simultaneous push and pop with count=0: the push happens, the pop is ignored, and underflow is set.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH.
- en=0 mid-fill: contents are held and the reroll state is held.
- underflow clears only on reset.

## Timing
- Reset values (asynchronous on rst=0): count=0, piece_valid=0, next_valid=0, piece_shape=0, piece_rot=0, next_shape=0, underflow=0, pointers=0, last_shape=7, reroll=0, state=FILL.
- All outputs are registered. Push and pop take effect at the clk edge where their conditions hold. Outputs reflect the new head/count in the following cycle (1-cycle latency).
- Maximum fill rate is 1 entry/cycle. From empty with every candidate acceptable, count=DEPTH after DEPTH cycles.
- A pop is not gated by rand_valid. Back-to-back pops every cycle are legal until empty.
- Deassertion of rst is not synchronised here; the system handles that.

## Test plan
- Reset fill: rst released, en=1, rand_valid=1, rand_in sequence 0x0001,0x0102,0x0203,0x0304 → count steps 1,2,3,4, then shapes 1,2,3,4 in order, piece_valid one cycle after the first push, next_shape=2, state READY.
- Rejection: rand_in[2:0]=7 for 5 cycles, then 0x0005 → no push during the 7s, then one push of shape 5, count=1.
- Anti-repeat: push 3, then rand_in=0x0003, then 0x0003 → the second 3 is rejected, the third 3 is accepted (reroll path), and the FIFO holds 3,3.
- Pop/push collision: FIFO full (1,2,3,4), piece_req with valid cand 6 → next cycle head=2, tail=6, count=4.
- Underflow: reset, en=0, pulse piece_req → count=0, underflow=1, and it stays 1 after a later fill.
- Async reset mid-operation: count=3, drop rst between edges → all outputs 0 immediately, without waiting for a clock edge, and last_shape=7 so the next push of any shape is accepted first try.
